// File: rtl/omu.sv
// Output move unit: streams 64-bit dsram words to an ICB target as pairs of
// 32-bit writes (low half, then high half), one transaction outstanding at a time.
module omu #(
    parameter int unsigned AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          trigger,
    input  logic [31:0]   output_base,
    input  logic [15:0]   xfer_len,
    output logic          busy,
    output logic          xfer_done,
    output logic          err_flag,
    output logic [AW-1:0] dsram_addr,
    output logic          dsram_rd_en,
    input  logic [63:0]   dsram_rdata,
    output logic          icb_cmd_valid,
    input  logic          icb_cmd_ready,
    output logic          icb_cmd_read,
    output logic [31:0]   icb_cmd_addr,
    output logic [31:0]   icb_cmd_wdata,
    output logic [3:0]    icb_cmd_wmask,
    input  logic          icb_rsp_valid,
    output logic          icb_rsp_ready,
    input  logic [31:0]   icb_rsp_rdata,
    input  logic          icb_rsp_err
);

    localparam int unsigned DW = 64;
    localparam int unsigned BW = 32;
    localparam int unsigned LW = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_CAP    = 3'd2,
        S_CMD_LO = 3'd3,
        S_RSP_LO = 3'd4,
        S_CMD_HI = 3'd5,
        S_RSP_HI = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t        r_state;
    logic [BW-1:0] r_base;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_idx;
    logic [DW-1:0] r_hold;

    logic [BW-1:0] w_addr_lo;
    logic [LW-1:0] w_idx_inc;
    logic          w_more;
    logic          w_unused_ok;

    // Byte address of the current word; wraps modulo 2^32 by construction.
    assign w_addr_lo = r_base + BW'({r_idx, 3'b000});
    assign w_idx_inc = r_idx + LW'(1);
    assign w_more    = (17'(r_idx) + 17'd1) < 17'(r_len);

    assign icb_cmd_read  = 1'b0;
    assign icb_cmd_wmask = 4'hF;

    // Read data is never consumed; the low hold half is forwarded straight from dsram.
    assign w_unused_ok = ^{icb_rsp_rdata, r_hold[BW-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_base        <= '0;
            r_len         <= '0;
            r_idx         <= '0;
            r_hold        <= '0;
            busy          <= 1'b0;
            xfer_done     <= 1'b0;
            err_flag      <= 1'b0;
            dsram_addr    <= '0;
            dsram_rd_en   <= 1'b0;
            icb_cmd_valid <= 1'b0;
            icb_cmd_addr  <= '0;
            icb_cmd_wdata <= '0;
            icb_rsp_ready <= 1'b0;
        end else begin
            xfer_done   <= 1'b0;
            dsram_rd_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (trigger) begin
                        r_base   <= output_base;
                        r_len    <= xfer_len;
                        r_idx    <= '0;
                        err_flag <= 1'b0;
                        busy     <= 1'b1;
                        if (xfer_len != '0) begin
                            r_state     <= S_RD;
                            dsram_rd_en <= 1'b1;
                            dsram_addr  <= '0;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RD: begin
                    r_state <= S_CAP;
                end
                S_CAP: begin
                    r_hold        <= dsram_rdata;
                    icb_cmd_valid <= 1'b1;
                    icb_cmd_addr  <= w_addr_lo;
                    icb_cmd_wdata <= dsram_rdata[BW-1:0];
                    r_state       <= S_CMD_LO;
                end
                S_CMD_LO: begin
                    if (icb_cmd_valid && icb_cmd_ready) begin
                        icb_cmd_valid <= 1'b0;
                        icb_rsp_ready <= 1'b1;
                        r_state       <= S_RSP_LO;
                    end
                end
                S_RSP_LO: begin
                    if (icb_rsp_valid && icb_rsp_ready) begin
                        if (icb_rsp_err) begin
                            err_flag <= 1'b1;
                        end
                        icb_rsp_ready <= 1'b0;
                        icb_cmd_valid <= 1'b1;
                        icb_cmd_addr  <= w_addr_lo + BW'(4);
                        icb_cmd_wdata <= r_hold[DW-1:BW];
                        r_state       <= S_CMD_HI;
                    end
                end
                S_CMD_HI: begin
                    if (icb_cmd_valid && icb_cmd_ready) begin
                        icb_cmd_valid <= 1'b0;
                        icb_rsp_ready <= 1'b1;
                        r_state       <= S_RSP_HI;
                    end
                end
                S_RSP_HI: begin
                    if (icb_rsp_valid && icb_rsp_ready) begin
                        if (icb_rsp_err) begin
                            err_flag <= 1'b1;
                        end
                        icb_rsp_ready <= 1'b0;
                        r_idx         <= w_idx_inc;
                        if (w_more) begin
                            r_state     <= S_RD;
                            dsram_rd_en <= 1'b1;
                            dsram_addr  <= AW'(w_idx_inc);
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    xfer_done <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_omu.sv
// Self-checking bench for omu: dsram and ICB target models plus a transfer-level
// reference built from the word-splitting rule.
module tb_omu;

    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          trigger;
    logic [31:0]   output_base;
    logic [15:0]   xfer_len;
    logic          busy;
    logic          xfer_done;
    logic          err_flag;
    logic [AW-1:0] dsram_addr;
    logic          dsram_rd_en;
    logic [63:0]   dsram_rdata;
    logic          icb_cmd_valid;
    logic          icb_cmd_ready;
    logic          icb_cmd_read;
    logic [31:0]   icb_cmd_addr;
    logic [31:0]   icb_cmd_wdata;
    logic [3:0]    icb_cmd_wmask;
    logic          icb_rsp_valid;
    logic          icb_rsp_ready;
    logic [31:0]   icb_rsp_rdata;
    logic          icb_rsp_err;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [0:63];
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    logic        mon_rdy[$];
    logic [31:0] mon_addr[$];
    logic [31:0] mon_data[$];

    int rsp_n = 0;
    int err_at = 0;
    int stall_left = 0;
    bit rand_rdy = 1'b0;
    bit rand_rsp = 1'b0;
    bit pend = 1'b0;
    bit pend_err = 1'b0;
    int cd = 0;

    omu #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .output_base(output_base),
        .xfer_len(xfer_len), .busy(busy), .xfer_done(xfer_done), .err_flag(err_flag),
        .dsram_addr(dsram_addr), .dsram_rd_en(dsram_rd_en), .dsram_rdata(dsram_rdata),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err)
    );

    always #5 clk = ~clk;

    // dsram: data appears exactly one cycle after the read strobe, garbage otherwise.
    always @(posedge clk) begin
        if (dsram_rd_en) dsram_rdata <= mem[dsram_addr[5:0]];
        else             dsram_rdata <= {$urandom, $urandom};
    end

    // ICB target: logs accepted writes, answers each one, optional stalls and delays.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icb_rsp_valid <= 1'b0;
            icb_rsp_err   <= 1'b0;
            pend = 1'b0;
        end else begin
            if (icb_rsp_valid && icb_rsp_ready) begin
                icb_rsp_valid <= 1'b0;
                icb_rsp_err   <= 1'b0;
            end
            if (icb_cmd_valid && icb_cmd_ready) begin
                wr_a.push_back(icb_cmd_addr);
                wr_d.push_back(icb_cmd_wdata);
                rsp_n++;
                pend = 1'b1;
                pend_err = (rsp_n == err_at);
                cd = rand_rsp ? int'($urandom_range(0, 3)) : 0;
            end
            if (pend) begin
                if (cd == 0) begin
                    icb_rsp_valid <= 1'b1;
                    icb_rsp_err   <= pend_err;
                    pend = 1'b0;
                end else begin
                    cd--;
                end
            end
            if (icb_cmd_valid && stall_left > 0) stall_left--;
            icb_cmd_ready <= (stall_left == 0) && (!rand_rdy || $urandom_range(0, 2) != 0);
        end
    end

    always @(negedge clk) begin
        if (icb_cmd_valid) begin
            mon_rdy.push_back(icb_cmd_ready);
            mon_addr.push_back(icb_cmd_addr);
            mon_data.push_back(icb_cmd_wdata);
        end
    end

    // Reference: each word i becomes (base+8i, low half) then (base+8i+4, high half).
    task automatic build_model(input logic [31:0] base, input int len);
        exp_a.delete();
        exp_d.delete();
        for (int i = 0; i < len; i++) begin
            exp_a.push_back(base + 32'(8 * i));
            exp_d.push_back(mem[i][31:0]);
            exp_a.push_back(base + 32'(8 * i) + 32'd4);
            exp_d.push_back(mem[i][63:32]);
        end
    endtask

    task automatic clear_logs();
        wr_a.delete();
        wr_d.delete();
        mon_rdy.delete();
        mon_addr.delete();
        mon_data.delete();
        rsp_n = 0;
    endtask

    // Issues a trigger (caller sits just after an edge) and waits for xfer_done.
    task automatic do_xfer(input logic [31:0] base, input logic [15:0] len, input int retrig,
                           output int lat, output int busy_cyc);
        trigger = 1'b1;
        output_base = base;
        xfer_len = len;
        lat = -1;
        busy_cyc = 0;
        for (int n = 1; n <= 3000; n++) begin
            @(posedge clk);
            #1;
            trigger = (n == retrig);
            if (n == retrig) begin
                output_base = ~base;
                xfer_len = len + 16'd1;
            end else if (n == 1) begin
                output_base = $urandom;
                xfer_len = 16'($urandom);
            end
            if (busy) busy_cyc++;
            if (xfer_done) begin
                lat = n;
                break;
            end
        end
        trigger = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, xfer_done, err_flag, dsram_rd_en, icb_cmd_valid, icb_rsp_ready, icb_cmd_read} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000000",
                     {busy, xfer_done, err_flag, dsram_rd_en, icb_cmd_valid, icb_rsp_ready, icb_cmd_read});
        end
        checks++;
        if ({dsram_addr, icb_cmd_addr, icb_cmd_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_bus addr %h cmd_addr %h wdata %h want 0", dsram_addr, icb_cmd_addr, icb_cmd_wdata);
        end
        checks++;
        if (icb_cmd_wmask !== 4'hF) begin
            errors++;
            $display("FAIL reset_wmask got %h want f", icb_cmd_wmask);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int lat, bc;
        mem[0] = 64'h1111_2222_3333_4444;
        mem[1] = 64'h5555_6666_7777_8888;
        clear_logs();
        build_model(32'h1000_0000, 2);
        do_xfer(32'h1000_0000, 16'd2, 0, lat, bc);
        checks++;
        if (lat !== 14) begin errors++; $display("FAIL basic_latency got %0d want 14", lat); end
        checks++;
        if (wr_a.size() !== 4) begin errors++; $display("FAIL basic_count got %0d want 4", wr_a.size()); end
        for (int k = 0; k < 4 && k < wr_a.size(); k++) begin
            checks++;
            if (wr_a[k] !== exp_a[k] || wr_d[k] !== exp_d[k]) begin
                errors++;
                $display("FAIL basic_write%0d got %h/%h want %h/%h", k, wr_a[k], wr_d[k], exp_a[k], exp_d[k]);
            end
        end
        checks++;
        if (wr_d.size() == 4 && wr_d[1] !== 32'h1111_2222) begin
            errors++; $display("FAIL basic_hi_half got %h want 11112222", wr_d[1]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (xfer_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_pulse done %b busy %b want 0 0", xfer_done, busy);
        end
    endtask

    task automatic test_len0();
        int lat, bc;
        clear_logs();
        do_xfer(32'h2000_0000, 16'd0, 0, lat, bc);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL len0_latency got %0d want 2", lat); end
        checks++;
        if (bc !== 1) begin errors++; $display("FAIL len0_busy got %0d want 1", bc); end
        checks++;
        if (wr_a.size() !== 0 || mon_addr.size() !== 0) begin
            errors++; $display("FAIL len0_cmds got %0d want 0", mon_addr.size());
        end
    endtask

    task automatic test_stall();
        int lat, bc, lo_wait, lo_acc;
        logic [31:0] base;
        base = $urandom & 32'hFFFF_FFF8;
        mem[0] = {$urandom, $urandom};
        clear_logs();
        stall_left = 5;
        do_xfer(base, 16'd1, 0, lat, bc);
        lo_wait = 0;
        lo_acc = 0;
        for (int k = 0; k < mon_addr.size(); k++) begin
            if (mon_addr[k] == base) begin
                if (mon_rdy[k]) lo_acc++; else lo_wait++;
                checks++;
                if (mon_data[k] !== mem[0][31:0]) begin
                    errors++; $display("FAIL stall_stable cyc %0d got %h want %h", k, mon_data[k], mem[0][31:0]);
                end
            end
        end
        checks++;
        if (lo_wait !== 5 || lo_acc !== 1) begin
            errors++; $display("FAIL stall_cycles got wait %0d acc %0d want 5 1", lo_wait, lo_acc);
        end
        checks++;
        if (lat !== 13) begin errors++; $display("FAIL stall_latency got %0d want 13", lat); end
        checks++;
        if (wr_d.size() !== 2 || wr_d[0] !== mem[0][31:0] || wr_d[1] !== mem[0][63:32]) begin
            errors++; $display("FAIL stall_data got %0d writes want 2 correct", wr_d.size());
        end
    endtask

    task automatic test_err();
        int lat, bc;
        mem[0] = {$urandom, $urandom};
        mem[1] = {$urandom, $urandom};
        clear_logs();
        err_at = 2;
        build_model(32'h3000_0100, 2);
        do_xfer(32'h3000_0100, 16'd2, 0, lat, bc);
        err_at = 0;
        checks++;
        if (wr_a.size() !== 4 || lat !== 14) begin
            errors++; $display("FAIL err_continue got %0d writes lat %0d want 4 14", wr_a.size(), lat);
        end
        for (int k = 0; k < 4 && k < wr_a.size(); k++) begin
            checks++;
            if (wr_a[k] !== exp_a[k] || wr_d[k] !== exp_d[k]) begin
                errors++;
                $display("FAIL err_write%0d got %h/%h want %h/%h", k, wr_a[k], wr_d[k], exp_a[k], exp_d[k]);
            end
        end
        checks++;
        if (err_flag !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err_flag); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err_flag !== 1'b1) begin errors++; $display("FAIL err_hold got %b want 1", err_flag); end
        trigger = 1'b1;
        xfer_len = 16'd0;
        @(posedge clk);
        #1 trigger = 1'b0;
        checks++;
        if (err_flag !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", err_flag); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat, bc, dones, found;
        logic [31:0] base;
        for (int i = 0; i < 3; i++) mem[i] = {$urandom, $urandom};
        base = 32'h4000_0040;
        clear_logs();
        build_model(base, 3);
        do_xfer(base, 16'd3, 4, lat, bc);
        checks++;
        if (wr_a.size() !== 6 || lat !== 20) begin
            errors++; $display("FAIL retrig_count got %0d writes lat %0d want 6 20", wr_a.size(), lat);
        end
        for (int k = 0; k < 6 && k < wr_a.size(); k++) begin
            checks++;
            if (wr_a[k] !== exp_a[k] || wr_d[k] !== exp_d[k]) begin
                errors++;
                $display("FAIL retrig_write%0d got %h/%h want %h/%h", k, wr_a[k], wr_d[k], exp_a[k], exp_d[k]);
            end
        end
        // Abort in the high-half command phase.
        clear_logs();
        trigger = 1'b1;
        output_base = base;
        xfer_len = 16'd2;
        found = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1 trigger = 1'b0;
            if (icb_cmd_valid && icb_cmd_addr == base + 32'd4) begin
                found = 1;
                break;
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (found != 1 || {busy, icb_cmd_valid, icb_rsp_ready, dsram_rd_en, xfer_done} !== 5'b0 ||
            icb_cmd_addr !== 32'h0 || icb_cmd_wdata !== 32'h0) begin
            errors++;
            $display("FAIL abort_reset found %0d ctrl %b addr %h want 1 00000 0", found,
                     {busy, icb_cmd_valid, icb_rsp_ready, dsram_rd_en, xfer_done}, icb_cmd_addr);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (xfer_done || busy || icb_cmd_valid) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", dones); end
    endtask

    task automatic test_wrap();
        int lat, bc;
        mem[0] = {$urandom, $urandom};
        mem[1] = {$urandom, $urandom};
        clear_logs();
        do_xfer(32'hFFFF_FFF8, 16'd2, 0, lat, bc);
        checks++;
        if (wr_a.size() !== 4 || wr_a[2] !== 32'h0000_0000 || wr_a[3] !== 32'h0000_0004) begin
            errors++;
            $display("FAIL wrap_addr got %0d writes, addr2/3 %h %h want 00000000 00000004",
                     wr_a.size(), wr_a.size() > 3 ? wr_a[2] : 32'hx, wr_a.size() > 3 ? wr_a[3] : 32'hx);
        end
        checks++;
        if (wr_d.size() == 4 && wr_d[3] !== mem[1][63:32]) begin
            errors++; $display("FAIL wrap_data got %h want %h", wr_d[3], mem[1][63:32]);
        end
    endtask

    task automatic test_random();
        int lat, bc, len;
        logic [31:0] base;
        rand_rdy = 1'b1;
        rand_rsp = 1'b1;
        for (int it = 0; it < 8; it++) begin
            len = $urandom_range(1, 5);
            base = $urandom;
            for (int i = 0; i < len; i++) mem[i] = {$urandom, $urandom};
            clear_logs();
            err_at = $urandom_range(0, 2 * len);
            build_model(base, len);
            do_xfer(base, 16'(len), 0, lat, bc);
            checks++;
            if (lat < 6 * len + 2) begin
                errors++; $display("FAIL rand%0d_latency got %0d want >= %0d", it, lat, 6 * len + 2);
            end
            checks++;
            if (wr_a.size() !== exp_a.size()) begin
                errors++; $display("FAIL rand%0d_count got %0d want %0d", it, wr_a.size(), exp_a.size());
            end
            for (int k = 0; k < exp_a.size() && k < wr_a.size(); k++) begin
                checks++;
                if (wr_a[k] !== exp_a[k] || wr_d[k] !== exp_d[k]) begin
                    errors++;
                    $display("FAIL rand%0d_write%0d got %h/%h want %h/%h", it, k, wr_a[k], wr_d[k], exp_a[k], exp_d[k]);
                end
            end
            checks++;
            if (err_flag !== (err_at != 0)) begin
                errors++; $display("FAIL rand%0d_err got %b want %b", it, err_flag, err_at != 0);
            end
            err_at = 0;
            @(posedge clk);
            #1;
        end
        rand_rdy = 1'b0;
        rand_rsp = 1'b0;
    endtask

    initial begin
        trigger = 1'b0;
        output_base = '0;
        xfer_len = '0;
        icb_cmd_ready = 1'b1;
        icb_rsp_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_len0();
        test_stall();
        test_err();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/omu.md
OMU -- requirements
Module: omu

Interface
REQ-001 Parameter: AW, default 16; dsram word-address width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 trigger  input  1  start request, sampled in IDLE only.
REQ-005 output_base  input  32  byte address of the destination region, sampled on accepted trigger.
REQ-006 xfer_len  input  16  number of 64-bit words to move, sampled on accepted trigger.
REQ-007 busy  output  1  high from the accepted trigger until the DONE state is exited.
REQ-008 xfer_done  output  1  one-cycle completion pulse.
REQ-009 err_flag  output  1  sticky ICB response error.
REQ-010 dsram_addr  output  AW  dsram word address.
REQ-011 dsram_rd_en  output  1  dsram read strobe.
REQ-012 dsram_rdata  input  64  read data, valid exactly 1 cycle after dsram_rd_en.
REQ-013 icb_cmd_valid  output  1  ICB command valid.
REQ-014 icb_cmd_ready  input  1  ICB command ready.
REQ-015 icb_cmd_read  output  1  ICB read flag; tied 0.
REQ-016 icb_cmd_addr  output  32  ICB byte address.
REQ-017 icb_cmd_wdata  output  32  ICB write data.
REQ-018 icb_cmd_wmask  output  4  ICB byte mask; tied 4'hF.
REQ-019 icb_rsp_valid  input  1  ICB response valid.
REQ-020 icb_rsp_ready  output  1  ICB response ready.
REQ-021 icb_rsp_rdata  input  32  ICB read data; unused.
REQ-022 icb_rsp_err  input  1  ICB response error.

Function
REQ-023 The block SHALL be an ICB initiator that splits each 64-bit dsram word into two 32-bit ICB writes: low half first, high half second.
REQ-024 The FSM SHALL have these states: IDLE, RD, CAP, CMD_LO, RSP_LO, CMD_HI, RSP_HI, DONE.
REQ-025 IDLE SHALL do the following on trigger: latch base/len, clear word index i and err_flag, assert busy, then go to RD if len != 0, else to DONE.
REQ-026 RD SHALL drive dsram_rd_en=1 and dsram_addr=i[AW-1:0] for exactly one cycle, then go to CAP.
REQ-027 CAP SHALL register dsram_rdata into a 64-bit holding register, then go to CMD_LO.
REQ-028 CMD_LO SHALL drive icb_cmd_valid=1, addr=base+8*i, wdata=hold[31:0].
REQ-029 On cmd_valid&cmd_ready, CMD_LO SHALL go to RSP_LO.
REQ-030 CMD_HI SHALL drive addr=base+8*i+4, wdata=hold[63:32], with the same handshake rule as CMD_LO.
REQ-031 Once asserted, icb_cmd_valid SHALL stay high, with addr/wdata stable, until accepted.
REQ-032 Address arithmetic SHALL be 32-bit modulo 2^32; wrap-around is permitted, not flagged.
REQ-033 At most one ICB transaction SHALL be outstanding; icb_rsp_ready SHALL be 1 only in RSP_LO/RSP_HI.
REQ-034 On rsp_valid&rsp_ready, RSP_LO SHALL go to CMD_HI.
REQ-035 On rsp_valid&rsp_ready, RSP_HI SHALL increment i, then go to RD if i+1 < len, else to DONE.
REQ-036 Any accepted response with icb_rsp_err=1 SHALL set err_flag; the transfer SHALL continue unaltered.
REQ-037 DONE SHALL pulse xfer_done for one cycle, deassert busy, and return to IDLE.
REQ-038 err_flag SHALL hold until the next accepted trigger.
REQ-039 A trigger outside IDLE SHALL be ignored, and input changes during a transfer SHALL have no effect.
REQ-040 With zero wait states (ready high, response one cycle after the command), each word SHALL take 6 cycles.
REQ-041 Total latency SHALL be 6*len+2 cycles from trigger to the xfer_done pulse.
REQ-042 A response arriving outside RSP states SHALL be ignored.

Reset
REQ-043 While rst_n=0 (asynchronous), the FSM SHALL be IDLE.
REQ-044 During reset, all outputs SHALL be 0 except icb_cmd_wmask=4'hF; i, hold and latched base/len SHALL be 0.
REQ-045 Reset mid-transfer SHALL abort immediately, with no xfer_done pulse; the block SHALL restart only on a new trigger.

Verification
REQ-046 base=0x1000_0000, len=2, dsram[0]=0x1111_2222_3333_4444, dsram[1]=0x5555_6666_7777_8888, zero wait -> writes (0x10000000,0x33334444), (0x10000004,0x11112222), (0x10000008,0x77778888), (0x1000000C,0x55556666); xfer_done 14 cycles after trigger.
REQ-047 len=0 -> no ICB command; xfer_done 2 cycles after trigger; busy high for 1 cycle.
REQ-048 icb_cmd_ready held low 5 cycles on the first command -> valid/addr/wdata stable for all 5 cycles; a single acceptance; data correct.
REQ-049 icb_rsp_err=1 on the 2nd response of a len=2 transfer -> all 4 writes issued; err_flag=1 after xfer_done; err_flag cleared by the next trigger.
REQ-050 Second trigger during a busy transfer -> ignored, exactly 2*len writes issued; rst_n pulsed low in CMD_HI -> outputs immediately reset, no xfer_done pulse.
REQ-051 base=0xFFFF_FFF8, len=2 -> second-word addresses 0x0000_0000 and 0x0000_0004.
